// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: RAW hazard detection and EX operand forwarding control for a
// five-stage pipeline. Shadow slots mirror the EX, MEM and WB stages so that
// every decision can be made from registered pipeline state.
// Build option: define HAZARD_FWD_EN for full forwarding (only load-use stalls).
// Without it, both forwarding selects are tied to 0 and a consumer is stalled
// until its producer has reached WB (write-before-read register file).

module hazard_fwd_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    output logic        stall,
    output logic        bubble,
    output logic [1:0]  ALU_SrcA_fwd,
    output logic [1:0]  ALU_SrcB_fwd,
    output logic [15:0] stall_cnt
);

    logic        exValid_q, exUsesRs_q, exUsesRt_q, exRegwrite_q, exMemread_q;
    logic [4:0]  exRs_q, exRt_q, exRd_q;
    logic        exValid_d, exUsesRs_d, exUsesRt_d, exRegwrite_d, exMemread_d;
    logic [4:0]  exRs_d, exRt_d, exRd_d;
    logic        memValid_q, memRegwrite_q, memMemread_q;
    logic [4:0]  memRd_q;
    logic        wbValid_q, wbRegwrite_q;
    logic [4:0]  wbRd_q;
    logic [15:0] stallCnt_q, stallCnt_d;

    logic        exProd, memProd;
    logic        idDepEx;
    logic        hazard;
    logic        stallInt, bubbleInt;
    logic [1:0]  selA, selB;

    // A slot only produces a value when it is real, writes, and targets a non-zero register.
    assign exProd  = exValid_q & exRegwrite_q & (exRd_q != 5'd0);
    assign memProd = memValid_q & memRegwrite_q & (memRd_q != 5'd0);

    assign idDepEx = id_valid & exProd &
                     ((id_uses_rs & (id_rs == exRd_q)) | (id_uses_rt & (id_rt == exRd_q)));

`ifdef HAZARD_FWD_EN
    logic wbProd;

    assign wbProd = wbValid_q & wbRegwrite_q & (wbRd_q != 5'd0);

    // With forwarding, only a load still in EX cannot supply its value in time.
    assign hazard = idDepEx & exMemread_q;

    // Operand selects: nearest non-load producer in MEM wins, otherwise WB, otherwise register file.
    always_comb begin
        selA = 2'd0;
        selB = 2'd0;
        if (exValid_q && exUsesRs_q) begin
            if (memProd && !memMemread_q && (memRd_q == exRs_q)) begin
                selA = 2'd2;
            end else if (wbProd && (wbRd_q == exRs_q)) begin
                selA = 2'd1;
            end
        end
        if (exValid_q && exUsesRt_q) begin
            if (memProd && !memMemread_q && (memRd_q == exRt_q)) begin
                selB = 2'd2;
            end else if (wbProd && (wbRd_q == exRt_q)) begin
                selB = 2'd1;
            end
        end
    end
`else
    logic idDepMem;
    logic unusedSlotBits;

    assign idDepMem = id_valid & memProd &
                      ((id_uses_rs & (id_rs == memRd_q)) | (id_uses_rt & (id_rt == memRd_q)));

    // No bypass paths: wait until the producer has left both EX and MEM.
    assign hazard = idDepEx | idDepMem;
    assign selA   = 2'd0;
    assign selB   = 2'd0;

    // Source and WB fields only feed the forwarding muxes; fold them so the full shadow pipeline stays intact.
    assign unusedSlotBits = ^{exRs_q, exRt_q, exUsesRs_q, exUsesRt_q, exMemread_q,
                              memMemread_q, wbValid_q, wbRd_q, wbRegwrite_q};
`endif

    // A flush squashes the ID instruction, so it never needs to be held.
    assign stallInt     = hazard & ~flush;
    assign bubbleInt    = hazard | flush;
    assign stall        = stallInt;
    assign bubble       = bubbleInt;
    assign ALU_SrcA_fwd = selA;
    assign ALU_SrcB_fwd = selB;
    assign stall_cnt    = stallCnt_q;

    // Next EX slot: the ID instruction, or an empty bubble; stall counter saturates.
    always_comb begin
        exValid_d    = 1'b0;
        exRs_d       = 5'd0;
        exRt_d       = 5'd0;
        exUsesRs_d   = 1'b0;
        exUsesRt_d   = 1'b0;
        exRd_d       = 5'd0;
        exRegwrite_d = 1'b0;
        exMemread_d  = 1'b0;
        if (!bubbleInt) begin
            exValid_d    = id_valid;
            exRs_d       = id_rs;
            exRt_d       = id_rt;
            exUsesRs_d   = id_uses_rs;
            exUsesRt_d   = id_uses_rt;
            exRd_d       = id_rd;
            exRegwrite_d = id_regwrite;
            exMemread_d  = id_memread;
        end
        stallCnt_d = stallCnt_q;
        if (stallInt && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // Shadow pipeline advance EX->MEM->WB each cycle; reset empties every slot immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exValid_q     <= 1'b0;
            exRs_q        <= 5'd0;
            exRt_q        <= 5'd0;
            exUsesRs_q    <= 1'b0;
            exUsesRt_q    <= 1'b0;
            exRd_q        <= 5'd0;
            exRegwrite_q  <= 1'b0;
            exMemread_q   <= 1'b0;
            memValid_q    <= 1'b0;
            memRd_q       <= 5'd0;
            memRegwrite_q <= 1'b0;
            memMemread_q  <= 1'b0;
            wbValid_q     <= 1'b0;
            wbRd_q        <= 5'd0;
            wbRegwrite_q  <= 1'b0;
            stallCnt_q    <= 16'd0;
        end else begin
            exValid_q     <= exValid_d;
            exRs_q        <= exRs_d;
            exRt_q        <= exRt_d;
            exUsesRs_q    <= exUsesRs_d;
            exUsesRt_q    <= exUsesRt_d;
            exRd_q        <= exRd_d;
            exRegwrite_q  <= exRegwrite_d;
            exMemread_q   <= exMemread_d;
            memValid_q    <= exValid_q;
            memRd_q       <= exRd_q;
            memRegwrite_q <= exRegwrite_q;
            memMemread_q  <= exMemread_q;
            wbValid_q     <= memValid_q;
            wbRd_q        <= memRd_q;
            wbRegwrite_q  <= memRegwrite_q;
            stallCnt_q    <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: scoreboard bench for hazard_fwd_ctrl. A driver issues
// instructions (directed scenarios plus random traffic), an instruction-history
// model predicts the outputs and queues them, and a negedge monitor compares.
// Follows the HAZARD_FWD_EN build option of the design.

module tb_hazard_fwd_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       urs;
        logic       urt;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic [1:0]  selA;
        logic [1:0]  selB;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        stall, bubble;
    logic [1:0]  ALU_SrcA_fwd, ALU_SrcB_fwd;
    logic [15:0] stall_cnt;

    exp_t        expQ[$];
    instr_t      hist[3];
    logic [15:0] modelCnt;
    int          checks = 0;
    int          errors = 0;

    hazard_fwd_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall), .bubble(bubble), .ALU_SrcA_fwd(ALU_SrcA_fwd),
        .ALU_SrcB_fwd(ALU_SrcB_fwd), .stall_cnt(stall_cnt)
    );

    always #10 clk = ~clk;

    function automatic instr_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                                  logic [4:0] rd, logic rw, logic mr);
        instr_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
        i.rd = rd; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    // True when instruction p will write register r (register 0 is never written).
    function automatic logic writes(instr_t p, logic [4:0] r);
        return p.v && p.rw && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    function automatic logic dependsOn(instr_t c, instr_t p);
        return c.v && ((c.urs && writes(p, c.rs)) || (c.urt && writes(p, c.rt)));
    endfunction

    // Select for an operand of the instruction now in EX: one stage ahead (non-load) -> 2, two ahead -> 1.
    function automatic logic [1:0] fwdSel(logic uses, logic [4:0] r);
        if (!FwdEn || !hist[0].v || !uses) return 2'd0;
        if (writes(hist[1], r) && !hist[1].mr) return 2'd2;
        if (writes(hist[2], r)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < 3; k++) hist[k] = '0;
        modelCnt = 16'd0;
    endtask

    // Predict this cycle's outputs from the ID instruction, then advance history past the coming edge.
    task automatic modelStep(input instr_t id, input logic fl, output exp_t e);
        logic hz;
        if (FwdEn) hz = dependsOn(id, hist[0]) && hist[0].mr;
        else       hz = dependsOn(id, hist[0]) || dependsOn(id, hist[1]);
        e.stall  = hz && !fl;
        e.bubble = hz || fl;
        e.selA   = fwdSel(hist[0].urs, hist[0].rs);
        e.selB   = fwdSel(hist[0].urt, hist[0].rt);
        e.cnt    = modelCnt;
        hist[2]  = hist[1];
        hist[1]  = hist[0];
        hist[0]  = e.bubble ? instr_t'('0) : id;
        if (e.stall && modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveInputs(input instr_t id, input logic fl);
        id_valid    = id.v;
        id_rs       = id.rs;
        id_rt       = id.rt;
        id_uses_rs  = id.urs;
        id_uses_rt  = id.urt;
        id_rd       = id.rd;
        id_regwrite = id.rw;
        id_memread  = id.mr;
        flush       = fl;
    endtask

    task automatic applyStimulus(input instr_t id, input logic fl, output logic stalled);
        exp_t e;
        @(posedge clk);
        #1;
        driveInputs(id, fl);
        modelStep(id, fl, e);
        expQ.push_back(e);
        stalled = e.stall;
    endtask

    // Present an instruction until the pipeline accepts it (bounded; at most two stall cycles).
    task automatic issueInstr(input instr_t id, input logic fl);
        logic s;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(id, fl, s);
            if (!s) break;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) issueInstr('0, 1'b0);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_stall"},  {15'd0, stall},         16'd0);
        checkOutput({tag, "_bubble"}, {15'd0, bubble},        16'd0);
        checkOutput({tag, "_selA"},   {14'd0, ALU_SrcA_fwd},  16'd0);
        checkOutput({tag, "_selB"},   {14'd0, ALU_SrcB_fwd},  16'd0);
        checkOutput({tag, "_cnt"},    stall_cnt,              16'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        driveInputs('0, 1'b0);
        rst = 1'b1;
        modelClear();
        #1;
        checkZeroOutputs("rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic expectCnt(input string name, input logic [15:0] exp);
        @(negedge clk);
        #1;
        checkOutput(name, stall_cnt, exp);
    endtask

    // Pulse reset between edges while a consumer is held, then confirm the stall is gone.
    task automatic midStallReset(input instr_t prod, input instr_t cons);
        logic s;
        exp_t e;
        issueInstr(prod, 1'b0);
        applyStimulus(cons, 1'b0, s);
        checkOutput("midrst_setup_stall", {15'd0, s}, 16'd1);
        #12;
        rst = 1'b1;
        modelClear();
        #1;
        checkZeroOutputs("midrst");
        #1;
        rst = 1'b0;
        #1;
        modelStep(cons, 1'b0, e);
        checkOutput("postrst_stall",  {15'd0, stall},  {15'd0, e.stall});
        checkOutput("postrst_bubble", {15'd0, bubble}, {15'd0, e.bubble});
        checkOutput("postrst_cnt",    stall_cnt,       e.cnt);
        checkOutput("postrst_nostall", {15'd0, stall}, 16'd0);
    endtask

    function automatic instr_t randInstr();
        instr_t i;
        i.v   = ($urandom_range(0, 7) != 0);
        i.rs  = 5'($urandom_range(0, 3));
        i.rt  = 5'($urandom_range(0, 3));
        i.urs = 1'($urandom_range(0, 1));
        i.urt = 1'($urandom_range(0, 1));
        i.rd  = 5'($urandom_range(0, 3));
        i.rw  = ($urandom_range(0, 3) != 0);
        i.mr  = i.rw && ($urandom_range(0, 2) == 0);
        return i;
    endfunction

    // Monitor: pop the prediction queued for this cycle and compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("stall",     {15'd0, stall},        {15'd0, e.stall});
                checkOutput("bubble",    {15'd0, bubble},       {15'd0, e.bubble});
                checkOutput("SrcA_fwd",  {14'd0, ALU_SrcA_fwd}, {14'd0, e.selA});
                checkOutput("SrcB_fwd",  {14'd0, ALU_SrcB_fwd}, {14'd0, e.selB});
                checkOutput("stall_cnt", stall_cnt,             e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1;
        driveInputs('0, 1'b0);
        modelClear();
        #5;
        checkZeroOutputs("init");
        @(posedge clk);
        #3;
        rst = 1'b0;

        // add r3 ; sub r?, r3, r4
        doReset();
        issueInstr(mk(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0), 1'b0);
        issueInstr(mk(1, 5'd3, 5'd4, 1, 1, 5'd6, 1, 0), 1'b0);
        idle(3);
        expectCnt("addsub_cnt", FwdEn ? 16'd0 : 16'd2);

        // lw r5 ; add r?, r1, r5
        doReset();
        issueInstr(mk(1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1), 1'b0);
        issueInstr(mk(1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0), 1'b0);
        idle(3);
        expectCnt("loaduse_cnt", FwdEn ? 16'd1 : 16'd2);

        // writer of r0 followed by reader of r0
        doReset();
        issueInstr(mk(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0), 1'b0);
        issueInstr(mk(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0), 1'b0);
        idle(3);
        expectCnt("r0_cnt", 16'd0);

        // load-use colliding with a flush
        doReset();
        issueInstr(mk(1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1), 1'b0);
        issueInstr(mk(1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0), 1'b1);
        idle(3);
        expectCnt("flush_cnt", 16'd0);

        // producer and consumer one instruction apart
        doReset();
        issueInstr(mk(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0), 1'b0);
        issueInstr(mk(1, 5'd8, 5'd9, 1, 1, 5'd10, 1, 0), 1'b0);
        issueInstr(mk(1, 5'd4, 5'd3, 1, 1, 5'd11, 1, 0), 1'b0);
        idle(3);
        expectCnt("gap1_cnt", FwdEn ? 16'd0 : 16'd1);

        // reset pulse in the middle of a stall
        doReset();
        midStallReset(mk(1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1), mk(1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0));
        idle(3);
        expectCnt("midrst_cnt", 16'd0);

        // random traffic on a small register set to provoke hazards
        doReset();
        for (int n = 0; n < 400; n++) begin
            issueInstr(randInstr(), ($urandom_range(0, 9) == 0));
        end
        idle(3);

        @(negedge clk);
        #1;
        checkOutput("queue_drain", 16'(expQ.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
